// File: rtl/tristate_bus_arbiter_if.sv
// Bundle of bus-sharing signals between the tri-state arbiter (master) and its requesters (slave).
interface tristate_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] owner;
    logic             busy;
    logic             tmo;

    modport master (
        input  req,
        output gnt,
        output owner,
        output busy,
        output tmo
    );

    modport slave (
        output req,
        input  gnt,
        input  owner,
        input  busy,
        input  tmo
    );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter with hold timeout driving one-hot tri-state enables.
// Define TRISTATE_BUS_TURNAROUND_EN to insert one all-disabled cycle on every owner change.
module tristate_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    tristate_bus_arbiter_if.master       bus
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1
`ifdef TRISTATE_BUS_TURNAROUND_EN
        ,
        S_TURN  = 2'd2
`endif
    } state_t;

    state_t           state_reg, state_next;
    logic [N_REQ-1:0] gnt_reg, gnt_next;
    logic [IDX_W-1:0] owner_reg, owner_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next;
    logic [7:0]       cnt_reg, cnt_next;
    logic             tmo_reg, tmo_next;

    logic [N_REQ-1:0] req_w;
    logic [IDX_W-1:0] owner_inc;
    logic             release_evt;
    logic             timeout_evt;
    logic [IDX_W-1:0] arb_start;
    logic [N_REQ-1:0] arb_mask;
    logic [N_REQ-1:0] arb_req;
    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic [N_REQ-1:0] win_onehot;

    assign req_w       = bus.req;
    assign owner_inc   = (owner_reg == IDX_W'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;
    assign release_evt = !req_w[owner_reg];
    assign timeout_evt = req_w[owner_reg] && (cnt_reg == 8'(MAX_HOLD));

    // While granted, the search starts past the outgoing owner and excludes it.
    always_comb begin
        arb_start = ptr_reg;
        arb_mask  = '0;
        if (state_reg == S_GRANT) begin
            arb_start = owner_inc;
            arb_mask  = '0;
            arb_mask[owner_reg] = 1'b1;
        end
    end

    assign arb_req = req_w & ~arb_mask;

    // Walk offsets from high to low so the smallest offset from arb_start wins.
    always_comb begin
        int               pos;
        logic [IDX_W-1:0] pos_idx;
        arb_found = 1'b0;
        arb_idx   = '0;
        pos       = 0;
        pos_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = int'(arb_start) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            pos_idx = pos[IDX_W-1:0];
            if (arb_req[pos_idx]) begin
                arb_found = 1'b1;
                arb_idx   = pos_idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign win_onehot[gi] = arb_found && (arb_idx == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        tmo_next   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (arb_found) begin
                    gnt_next   = win_onehot;
                    owner_next = arb_idx;
                    cnt_next   = 8'd1;
                    state_next = S_GRANT;
                end
            end

            S_GRANT: begin
                if (release_evt || timeout_evt) begin
                    ptr_next = owner_inc;
                    // A simultaneous release suppresses the timeout pulse.
                    tmo_next = !release_evt;
`ifdef TRISTATE_BUS_TURNAROUND_EN
                    gnt_next   = '0;
                    cnt_next   = 8'd0;
                    state_next = S_TURN;
`else
                    if (arb_found) begin
                        gnt_next   = win_onehot;
                        owner_next = arb_idx;
                        cnt_next   = 8'd1;
                    end else begin
                        gnt_next   = '0;
                        cnt_next   = 8'd0;
                        state_next = S_IDLE;
                    end
`endif
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end

`ifdef TRISTATE_BUS_TURNAROUND_EN
            S_TURN: begin
                gnt_next = '0;
                if (arb_found) begin
                    gnt_next   = win_onehot;
                    owner_next = arb_idx;
                    cnt_next   = 8'd1;
                    state_next = S_GRANT;
                end else begin
                    state_next = S_IDLE;
                end
            end
`endif

            default: begin
                gnt_next   = '0;
                cnt_next   = 8'd0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            gnt_reg   <= '0;
            owner_reg <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= 8'd0;
            tmo_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            tmo_reg   <= tmo_next;
        end
    end

    assign bus.gnt   = gnt_reg;
    assign bus.owner = owner_reg;
    assign bus.busy  = |gnt_reg;
    assign bus.tmo   = tmo_reg;
endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Round-robin arbiter that shares one tri-state bus among `N_REQ` requesters. Its one-hot grant drives the enable inputs of the requesters' `bufif1`/`assign y = en ? a : 1'bz` buffers, so at most one driver is enabled at any time. An encoded owner index selects the matching read-back mux path. A hold timeout stops any single requester from monopolising the bus.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters. Legal range 2..16.
- `MAX_HOLD`, default 8: maximum consecutive cycles one grant may last. Legal range 2..255.

Ports:
- `clk`, input, 1: single clock. All state updates occur on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `req`, input, `N_REQ`: per-requester bus request, level-sensitive. Held high while the requester wants the bus.
- `gnt`, output, `N_REQ`: one-hot grant, registered. Wired directly to the tri-state enables.
- `owner`, output, `$clog2(N_REQ)`: index of the granted requester. Holds its last value when idle.
- `busy`, output, 1: high whenever any `gnt` bit is high.
- `tmo`, output, 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- Internal state: FSM {IDLE, GRANT, TURN}; round-robin pointer `ptr`; hold counter `cnt` (8 bit).
- Reset values: `gnt`=0, `owner`=0, `busy`=0, `tmo`=0, `ptr`=0, `cnt`=0, state=IDLE.
- Arbitration: pick the first index i with `req[i]` set, searching from `ptr` upward and wrapping modulo `N_REQ`.
- IDLE:
  - If any `req` is set, arbitrate. Set `gnt[i]`, `owner`=i, `cnt`=1, and go to GRANT.
  - Otherwise remain in IDLE.
- GRANT (outgoing owner = o):
  - **Release:** `req[o]`=0. Set `ptr`=(o+1) mod `N_REQ`.
  - **Timeout:** `req[o]`=1 and `cnt`==`MAX_HOLD`. Set `ptr`=(o+1) mod `N_REQ` and `tmo`=1 for one cycle.
  - If both conditions hold at the same edge, release wins and there is no `tmo` pulse.
  - On either event:
    - Without the macro: arbitrate immediately with `req[o]` masked. A winner gets the grant on the same edge. With no winner, go to IDLE.
    - With the macro: go to TURN.
  - Otherwise: hold the grant and increment `cnt`.
- The outgoing owner never wins the arbitration at its own release/timeout edge. It may win again one cycle later.
- TURN (macro only): `gnt`=0 for exactly one cycle. Then arbitrate as in IDLE, with no mask.
- `gnt` is never multi-hot in any cycle, including handoff.
- A non-owner `req` pulse that drops before being sampled at an arbitration edge is not remembered.

## Timing
- Grant latency from IDLE: `req` is sampled high at edge k, and `gnt` is visible after edge k.
- Release latency: `req[o]` is sampled low at edge e, and `gnt[o]`=0 after edge e.
- Handoff without the macro: the new `gnt` rises after edge e, with zero dead cycles.
- Handoff with the macro: the new `gnt` rises after edge e+1, with exactly one all-zero cycle.
- A grant lasts at most `MAX_HOLD` cycles.
- `tmo` is high for exactly the cycle after the revoke edge.
- `busy` and `owner` update on the same edges as `gnt`.
- Asynchronous `rst` clears all outputs immediately, without waiting for `clk`. Every tri-state driver is disabled and the bus floats to `z`.
- After `rst` deasserts, arbitration restarts from `ptr`=0 on the next edge.

## Configuration
- `TRISTATE_BUS_TURNAROUND_EN`
  - **Defined:** the TURN state is compiled in. Every change of owner passes through one cycle with all enables low, which prevents driver overlap on slow-release buffers.
  - **Undefined:** TURN is absent and handoff is back-to-back.

## Test plan
All scenarios use `N_REQ`=4 and `MAX_HOLD`=8.
- Reset: hold `rst`=1 with `req`=4'b1111 for 5 cycles. Expect `gnt`=0, `owner`=0, `busy`=0 and `tmo`=0 throughout. After release, expect `gnt`=4'b0001 at the first edge.
- Single request: `req`=4'b0100 at edge 1.
  - After edge 1, expect `gnt`=4'b0100, `owner`=2, `busy`=1.
  - Drop `req` at edge 4; after edge 4, expect `gnt`=0 and `busy`=0.
- Round-robin: `req`=4'b1111. Each owner drops its `req` for one cycle after holding the bus for 2 cycles, then reasserts. Expect the grant order 0,1,2,3,0, and `gnt` never multi-hot.
- Timeout: `req`=4'b0010 held for 20 cycles.
  - Expect `gnt`=4'b0010 for exactly 8 cycles, then a one-cycle `tmo` pulse.
  - Without the macro, expect `gnt`=0 for 1 cycle, then `gnt`=4'b0010 again.
  - Also cover the case where `req` drops at the edge where `cnt`==8: expect no `tmo`.
- Handoff with `req`=4'b0011 and owner 0 releasing at edge e:
  - Macro undefined: `gnt` goes from 4'b0001 to 4'b0010 with no gap.
  - Macro defined: `gnt` goes 4'b0001, then 4'b0000 for one cycle, then 4'b0010.
- Asynchronous reset mid-grant: assert `rst` between edges while `gnt`=4'b0100. Expect `gnt`=0 before the next edge. After deassert with `req`=4'b0110, expect the first grant to go to index 1.
